// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a show-ahead byte FIFO onto a UART line (8N1/8N2).
// One pop per frame, LSB first; CTS only gates the start of a new frame.
module fifo_uart_tx #(
    parameter int c_CLKSPERBIT = 104,
    parameter int c_DATAWIDTH  = 8,
    parameter int c_STOPBITS   = 1
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [c_DATAWIDTH-1:0] i_fifo_data,
    input  logic                   i_fifo_empty,
    output logic                   o_fifo_readen,
    input  logic                   i_cts,
    output logic                   o_tx,
    output logic                   o_busy
);

    localparam int BW = (c_CLKSPERBIT > 1) ? $clog2(c_CLKSPERBIT) : 1;
    localparam int IW = (c_DATAWIDTH > 1) ? $clog2(c_DATAWIDTH) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(c_CLKSPERBIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(c_DATAWIDTH - 1);
    localparam logic          STOP_LAST = (c_STOPBITS > 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [BW-1:0]          baud_q, baud_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   stop_q, stop_d;
    logic [c_DATAWIDTH-1:0] shreg_q, shreg_d;
    logic                   tx_q, tx_d;
    logic                   rd_q, rd_d;
    logic                   busy_q, busy_d;
    logic                   baud_wrap;

    assign baud_wrap     = (baud_q == BAUD_LAST);
    assign o_tx          = tx_q;
    assign o_fifo_readen = rd_q;
    assign o_busy        = busy_q;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        rd_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                idx_d  = '0;
                stop_d = 1'b0;
                if (!i_fifo_empty && i_cts) begin
                    shreg_d = i_fifo_data;
                    rd_d    = 1'b1;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    idx_d   = '0;
                    tx_d    = shreg_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (idx_q == BIT_LAST) begin
                        tx_d    = 1'b1;
                        stop_d  = 1'b0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        tx_d  = shreg_q[idx_d];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_wrap) begin
                    baud_d = '0;
                    if (stop_q == STOP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench for fifo_uart_tx with a show-ahead
// FIFO model and a UART line monitor per DUT instance.
module tb_fifo_uart_tx;

    localparam int CA = 4;
    localparam int SA = 1;
    localparam int CB = 2;
    localparam int SB = 2;
    localparam int W  = 8;
    localparam int FLA = (1 + W + SA) * CA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_a = 1'b1, cts_a = 1'b1, empty_a = 1'b1;
    logic [7:0] data_a = 8'h00;
    logic       rd_a, tx_a, busy_a;
    logic       rst_b = 1'b1, cts_b = 1'b1, empty_b = 1'b1;
    logic [7:0] data_b = 8'h00;
    logic       rd_b, tx_b, busy_b;

    logic [7:0] fq_a[$], fq_b[$];
    logic [7:0] exp_a[$], exp_b[$];
    int         starts_a[$];
    int         pops_a = 0, pops_b = 0;

    fifo_uart_tx #(.c_CLKSPERBIT(CA), .c_DATAWIDTH(W), .c_STOPBITS(SA)) dut_a (
        .i_clock(clk), .i_reset(rst_a), .i_fifo_data(data_a),
        .i_fifo_empty(empty_a), .o_fifo_readen(rd_a), .i_cts(cts_a),
        .o_tx(tx_a), .o_busy(busy_a)
    );

    fifo_uart_tx #(.c_CLKSPERBIT(CB), .c_DATAWIDTH(W), .c_STOPBITS(SB)) dut_b (
        .i_clock(clk), .i_reset(rst_b), .i_fifo_data(data_b),
        .i_fifo_empty(empty_b), .o_fifo_readen(rd_b), .i_cts(cts_b),
        .o_tx(tx_b), .o_busy(busy_b)
    );

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Show-ahead FIFO models: pop at the edge ending readen, flags follow.
    always @(posedge clk) begin
        if (rd_a) begin
            chk(fq_a.size() != 0, "pop_on_empty_a", 0, 1);
            if (fq_a.size() != 0) void'(fq_a.pop_front());
            pops_a++;
        end
        empty_a <= (fq_a.size() == 0);
        data_a  <= (fq_a.size() != 0) ? fq_a[0] : 8'h00;
    end

    always @(posedge clk) begin
        if (rd_b) begin
            chk(fq_b.size() != 0, "pop_on_empty_b", 0, 1);
            if (fq_b.size() != 0) void'(fq_b.pop_front());
            pops_b++;
        end
        empty_b <= (fq_b.size() == 0);
        data_b  <= (fq_b.size() != 0) ? fq_b[0] : 8'h00;
    end

    function automatic logic tx_of(input int k);
        return (k != 0) ? tx_b : tx_a;
    endfunction
    function automatic logic busy_of(input int k);
        return (k != 0) ? busy_b : busy_a;
    endfunction
    function automatic logic rd_of(input int k);
        return (k != 0) ? rd_b : rd_a;
    endfunction
    function automatic logic rst_of(input int k);
        return (k != 0) ? rst_b : rst_a;
    endfunction
    function automatic int exp_size(input int k);
        return (k != 0) ? exp_b.size() : exp_a.size();
    endfunction
    function automatic int fq_size(input int k);
        return (k != 0) ? fq_b.size() : fq_a.size();
    endfunction
    function automatic logic [7:0] exp_pop(input int k);
        if (k != 0) return exp_b.pop_front();
        return exp_a.pop_front();
    endfunction

    task automatic push(input int k, input logic [7:0] v, input bit expect_it);
        if (k != 0) begin
            fq_b.push_back(v);
            if (expect_it) exp_b.push_back(v);
        end else begin
            fq_a.push_back(v);
            if (expect_it) exp_a.push_back(v);
        end
    endtask

    // Line monitor: decodes one frame per start bit, checking every cycle.
    task automatic monitor(input int k);
        int c, s, fl, idx;
        bit abort;
        logic [7:0] b;
        logic [7:0] e;
        c  = (k != 0) ? CB : CA;
        s  = (k != 0) ? SB : SA;
        fl = (1 + W + s) * c;
        forever begin
            @(negedge clk);
            if (rst_of(k) !== 1'b0 || tx_of(k) !== 1'b0) continue;
            if (k == 0) starts_a.push_back(cyc);
            abort = 1'b0;
            b = 8'h00;
            for (int n = 0; n < fl; n++) begin
                if (n > 0) @(negedge clk);
                if (rst_of(k)) begin
                    abort = 1'b1;
                    break;
                end
                chk(busy_of(k) == 1'b1, "busy_in_frame", busy_of(k), 1);
                chk(rd_of(k) == (n == 0), "readen_pulse", rd_of(k), (n == 0));
                if (n < c) begin
                    chk(tx_of(k) == 1'b0, "start_level", tx_of(k), 0);
                end else if (n < c * (1 + W)) begin
                    idx = (n - c) / c;
                    if ((n - c) % c == 0) b[idx] = tx_of(k);
                    else chk(tx_of(k) == b[idx], "bit_stable", tx_of(k), b[idx]);
                end else begin
                    chk(tx_of(k) == 1'b1, "stop_level", tx_of(k), 1);
                end
            end
            if (abort) continue;
            if (exp_size(k) == 0) begin
                chk(1'b0, "unexpected_frame", b, 0);
            end else begin
                e = exp_pop(k);
                chk(b == e, "byte", b, e);
            end
            @(negedge clk);
            if (!rst_of(k))
                chk({tx_of(k), busy_of(k), rd_of(k)} == 3'b100, "idle_after_frame",
                    {tx_of(k), busy_of(k), rd_of(k)}, 3'b100);
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic wait_done(input int k, input int bound);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (exp_size(k) == 0 && fq_size(k) == 0 && !busy_of(k)) begin
                done = 1'b1;
                break;
            end
        end
        chk(done, "drain_timeout", exp_size(k), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_start(input int k, input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (tx_of(k) == 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        chk(seen, "start_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        // Reset then idle
        repeat (3) begin
            @(negedge clk);
            chk({tx_a, busy_a, rd_a} == 3'b100, "reset_a", {tx_a, busy_a, rd_a}, 3'b100);
            chk({tx_b, busy_b, rd_b} == 3'b100, "reset_b", {tx_b, busy_b, rd_b}, 3'b100);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (50) begin
            @(negedge clk);
            chk({tx_a, busy_a, rd_a} == 3'b100, "idle_a", {tx_a, busy_a, rd_a}, 3'b100);
            chk({tx_b, busy_b, rd_b} == 3'b100, "idle_b", {tx_b, busy_b, rd_b}, 3'b100);
        end

        // Single byte
        p0 = pops_a;
        push(0, 8'hA5, 1'b1);
        wait_done(0, 200);
        chk(pops_a == p0 + 1, "pops_single", pops_a - p0, 1);

        // Back-to-back
        p0 = pops_a;
        starts_a.delete();
        push(0, 8'h00, 1'b1);
        push(0, 8'hFF, 1'b1);
        push(0, 8'h55, 1'b1);
        wait_done(0, 600);
        chk(pops_a == p0 + 3, "pops_b2b", pops_a - p0, 3);
        chk(empty_a == 1'b1, "empty_after_b2b", empty_a, 1);
        chk(starts_a.size() == 3, "frames_b2b", starts_a.size(), 3);
        if (starts_a.size() == 3) begin
            chk(starts_a[1] - starts_a[0] == FLA + 1, "gap_1", starts_a[1] - starts_a[0], FLA + 1);
            chk(starts_a[2] - starts_a[1] == FLA + 1, "gap_2", starts_a[2] - starts_a[1], FLA + 1);
        end

        // Flow control
        cts_a = 1'b0;
        p0 = pops_a;
        push(0, 8'h12, 1'b1);
        push(0, 8'h34, 1'b1);
        repeat (100) begin
            @(negedge clk);
            chk({tx_a, busy_a} == 2'b10, "cts_hold", {tx_a, busy_a}, 2'b10);
        end
        chk(pops_a == p0, "cts_no_pop", pops_a - p0, 0);
        cts_a = 1'b1;
        wait_start(0, 10);
        repeat (10) @(negedge clk);
        cts_a = 1'b0;
        repeat (100) @(negedge clk);
        chk(pops_a == p0 + 1, "cts_one_pop", pops_a - p0, 1);
        chk(exp_a.size() == 1, "cts_byte2_held", exp_a.size(), 1);
        chk({tx_a, busy_a} == 2'b10, "cts_idle", {tx_a, busy_a}, 2'b10);
        cts_a = 1'b1;
        wait_done(0, 200);
        chk(pops_a == p0 + 2, "cts_two_pops", pops_a - p0, 2);

        // Reset mid-frame during data bit 3 of 0x3C
        push(0, 8'h3C, 1'b0);
        wait_start(0, 10);
        repeat (17) @(negedge clk);
        p0 = pops_a;
        rst_a = 1'b1;
        @(negedge clk);
        chk({tx_a, busy_a, rd_a} == 3'b100, "reset_abort", {tx_a, busy_a, rd_a}, 3'b100);
        @(negedge clk);
        rst_a = 1'b0;
        chk(pops_a == p0, "reset_no_pop", pops_a - p0, 0);
        push(0, 8'h81, 1'b1);
        wait_done(0, 200);
        chk(pops_a == p0 + 1, "pops_after_reset", pops_a - p0, 1);

        // Reset wins over a start condition
        p0 = pops_a;
        rst_a = 1'b1;
        push(0, 8'h11, 1'b1);
        repeat (4) begin
            @(negedge clk);
            chk({tx_a, busy_a, rd_a} == 3'b100, "reset_wins", {tx_a, busy_a, rd_a}, 3'b100);
        end
        chk(pops_a == p0, "reset_wins_pop", pops_a - p0, 0);
        rst_a = 1'b0;
        wait_done(0, 200);
        chk(pops_a == p0 + 1, "pops_after_hold", pops_a - p0, 1);

        // Divider corner: 2 clocks per bit, 2 stop bits
        p0 = pops_b;
        push(1, 8'h01, 1'b1);
        wait_done(1, 200);
        chk(pops_b == p0 + 1, "pops_corner", pops_b - p0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
